// File: rtl/addsub_pkg.sv
// addsub_pkg: shared FSM encoding and default widths for the add/sub arbiter
package addsub_pkg;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    localparam int W_DEF = 4;
    localparam int CNT_W = 8;
endpackage

// File: rtl/myaddsub.sv
// myaddsub: unsigned add, or subtract returning magnitude plus sign
module myaddsub #(
    parameter int W = 4
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         M,
    output logic [W:0]   S,
    output logic         sign
);
    // subtract always yields the magnitude; sign flags a negative difference
    always_comb begin
        S    = M ? (A < B ? {1'b0, B - A} : {1'b0, A - B}) : {1'b0, A} + {1'b0, B};
        sign = M & (A < B);
    end
endmodule

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: two requesters time-share one myaddsub through an IDLE/EXEC/RESP FSM
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter bit RR_EN = 1'b1,
    parameter int W     = W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [W-1:0]     req0_A,
    input  logic [W-1:0]     req0_B,
    input  logic             req0_M,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [W-1:0]     req1_A,
    input  logic [W-1:0]     req1_B,
    input  logic             req1_M,
    output logic             req1_ready,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [W:0]       S,
    output logic             sign,
    output logic [CNT_W-1:0] op_count
);
    state_t       state;
    logic         ptr;
    logic [W-1:0] a_q, b_q;
    logic         m_q, id_q;
    logic         gnt0, gnt1;
    logic [W:0]   s_x;
    logic         sign_x;

    // requester 1 wins when alone, or when both ask and the round-robin pointer favours it
    always_comb begin
        gnt1 = req1_valid & (~req0_valid | (RR_EN & ptr));
        gnt0 = req0_valid & ~gnt1;
    end

    assign req0_ready = ~rst & (state == IDLE) & gnt0;
    assign req1_ready = ~rst & (state == IDLE) & gnt1;
    assign resp_valid = (state == RESP);

    myaddsub #(.W(W)) u_myaddsub (
        .A    (a_q),
        .B    (b_q),
        .M    (m_q),
        .S    (s_x),
        .sign (sign_x)
    );

    // grant latches operands, EXEC captures the result, RESP holds it until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= 1'b0;
            id_q     <= 1'b0;
            S        <= '0;
            sign     <= 1'b0;
            resp_id  <= 1'b0;
            op_count <= '0;
        end else begin
            case (state)
                IDLE: if (gnt0 | gnt1) begin
                    state <= EXEC;
                    a_q   <= gnt1 ? req1_A : req0_A;
                    b_q   <= gnt1 ? req1_B : req0_B;
                    m_q   <= gnt1 ? req1_M : req0_M;
                    id_q  <= gnt1;
                    ptr   <= ~gnt1;
                end
                EXEC: begin
                    S       <= s_x;
                    sign    <= sign_x;
                    resp_id <= id_q;
                    state   <= RESP;
                end
                RESP: if (resp_ready) begin
                    state    <= IDLE;
                    op_count <= op_count + CNT_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
